// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
package seq_detect_pkg;

    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_CNT_W   = 8;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // A length outside 1..max means the detector is disabled.
    function automatic logic len_valid(input int len, input int max);
        return (len >= 1) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Combinational pattern comparator: compares the low len bits of the
// updated history against the pattern once enough bits have arrived.
module seq_match_cmp
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] hist_n,
    input  logic [MAX_LEN-1:0] pattern_q,
    input  logic [LEN_W-1:0]   len_q,
    input  logic [LEN_W-1:0]   fill_n,
    output logic               match
);

    localparam logic [MAX_LEN:0] ONE = 1;

    logic [MAX_LEN:0]   maskWide;
    logic [MAX_LEN-1:0] mask;

    // One extra bit so that len == MAX_LEN yields an all-ones mask.
    always_comb begin
        maskWide = (ONE << len_q) - ONE;
        mask     = maskWide[MAX_LEN-1:0];
        match    = len_valid(32'(len_q), MAX_LEN)
                   && (fill_n >= len_q)
                   && (((hist_n ^ pattern_q) & mask) == '0);
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector with run-time pattern, length and
// overlap mode, a one-cycle match pulse and a saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_bit,
    input  logic               inp_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] FILL_ONE = LEN_W'(1);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_n;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               seen_q, seen_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               match;

    assign hist_n = {hist_q[MAX_LEN-2:0], inp_bit};
    assign fill_n = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + FILL_ONE;

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist_n    (hist_n),
        .pattern_q (pattern_q),
        .len_q     (len_q),
        .fill_n    (fill_n),
        .match     (match)
    );

    // Load takes priority over a bit; count clear takes priority over increment.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        seen_d    = 1'b0;
        count_d   = count_q;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (inp_valid) begin
            hist_d = hist_n;
            fill_d = (match && (overlap_q == OVL_OFF)) ? '0 : fill_n;
            seen_d = match;
            if (match && (count_q != '1)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
        if (clr_count) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= OVL_ON;
            seen_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            seen_q    <= seen_d;
            count_q   <= count_d;
        end
    end

    assign seq_seen    = seen_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed vector table, corner-case sequences and
// random traffic against a bit-list reference model; two counter widths.
module tb_seq_detect_prog;

    logic       clk;
    logic       reset;
    logic       inpBit;
    logic       inpValid;
    logic       cfgLoad;
    logic [7:0] cfgPattern;
    logic [3:0] cfgLen;
    logic       cfgOverlap;
    logic       clrCount;
    logic       seqSeen8;
    logic [7:0] matchCount8;
    logic       seqSeen2;
    logic [1:0] matchCount2;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted bits, bits eligible since last restart, counts
    bit       bitsQ[$];
    int       armed;
    logic [7:0] patM;
    int       lenM;
    bit       ovlM;
    int       cnt8M;
    int       cnt2M;
    bit       expSeen;

    typedef struct {
        logic       b;
        logic       v;
        logic       ld;
        logic       clr;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       expSeen;
        logic [7:0] expCnt;
    } vec_t;

    vec_t tbl[$];

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .inp_bit     (inpBit),
        .inp_valid   (inpValid),
        .cfg_load    (cfgLoad),
        .cfg_pattern (cfgPattern),
        .cfg_len     (cfgLen),
        .cfg_overlap (cfgOverlap),
        .clr_count   (clrCount),
        .seq_seen    (seqSeen8),
        .match_count (matchCount8)
    );

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .inp_bit     (inpBit),
        .inp_valid   (inpValid),
        .cfg_load    (cfgLoad),
        .cfg_pattern (cfgPattern),
        .cfg_len     (cfgLen),
        .cfg_overlap (cfgOverlap),
        .clr_count   (clrCount),
        .seq_seen    (seqSeen2),
        .match_count (matchCount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        bitsQ.delete();
        armed   = 0;
        patM    = '0;
        lenM    = 0;
        ovlM    = 1'b1;
        cnt8M   = 0;
        cnt2M   = 0;
        expSeen = 1'b0;
    endfunction

    // A match means the most recent lenM accepted bits spell the pattern, oldest first
    function automatic void modelEdge();
        bit m;
        m = 1'b0;
        if (cfgLoad) begin
            patM = cfgPattern;
            lenM = int'(cfgLen);
            ovlM = cfgOverlap;
            bitsQ.delete();
            armed = 0;
        end else if (inpValid) begin
            bitsQ.push_back(inpBit);
            if (bitsQ.size() > 8) void'(bitsQ.pop_front());
            armed++;
            if (lenM >= 1 && lenM <= 8 && armed >= lenM) begin
                m = 1'b1;
                for (int k = 0; k < lenM; k++) begin
                    if (bitsQ[bitsQ.size() - 1 - k] != patM[k]) m = 1'b0;
                end
            end
            if (m && !ovlM) armed = 0;
        end
        expSeen = m;
        if (m) begin
            if (cnt8M < 255) cnt8M++;
            if (cnt2M < 3) cnt2M++;
        end
        if (clrCount) begin
            cnt8M = 0;
            cnt2M = 0;
        end
    endfunction

    task automatic checkOutput();
        check("seen8", int'(seqSeen8), int'(expSeen));
        check("seen2", int'(seqSeen2), int'(expSeen));
        check("count8", int'(matchCount8), cnt8M);
        check("count2", int'(matchCount2), cnt2M);
    endtask

    // Drive one cycle of inputs, let the model follow the edge, check #1 later
    task automatic applyStimulus(input logic b, input logic v, input logic ld,
                                 input logic clr, input logic [7:0] pat,
                                 input logic [3:0] len, input logic ovl);
        inpBit     = b;
        inpValid   = v;
        cfgLoad    = ld;
        clrCount   = clr;
        cfgPattern = pat;
        cfgLen     = len;
        cfgOverlap = ovl;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic bitStep(input logic b, input logic v);
        applyStimulus(b, v, 1'b0, 1'b0, cfgPattern, cfgLen, cfgOverlap);
    endtask

    task automatic doReset();
        reset = 1'b0;
        #2;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic void addVec(input logic b, input logic v, input logic ld,
                                   input logic clr, input logic [7:0] pat,
                                   input logic [3:0] len, input logic ovl,
                                   input logic es, input logic [7:0] ec);
        vec_t t;
        t.b = b; t.v = v; t.ld = ld; t.clr = clr; t.pat = pat; t.len = len;
        t.ovl = ovl; t.expSeen = es; t.expCnt = ec;
        tbl.push_back(t);
    endfunction

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;

        reset = 1'b0; inpBit = 1'b0; inpValid = 1'b0; cfgLoad = 1'b0;
        cfgPattern = '0; cfgLen = '0; cfgOverlap = 1'b0; clrCount = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b1;

        // Overlapping 1011 over 1011011, then the same non-overlapping, then gaps
        addVec(0,0,1,0,8'h0B,4,1, 0,0);
        addVec(1,1,0,0,8'h0B,4,1, 0,0);
        addVec(0,1,0,0,8'h0B,4,1, 0,0);
        addVec(1,1,0,0,8'h0B,4,1, 0,0);
        addVec(1,1,0,0,8'h0B,4,1, 1,1);
        addVec(0,1,0,0,8'h0B,4,1, 0,1);
        addVec(1,1,0,0,8'h0B,4,1, 0,1);
        addVec(1,1,0,0,8'h0B,4,1, 1,2);
        addVec(0,0,1,1,8'h0B,4,0, 0,0);
        addVec(1,1,0,0,8'h0B,4,0, 0,0);
        addVec(0,1,0,0,8'h0B,4,0, 0,0);
        addVec(1,1,0,0,8'h0B,4,0, 0,0);
        addVec(1,1,0,0,8'h0B,4,0, 1,1);
        addVec(0,1,0,0,8'h0B,4,0, 0,1);
        addVec(1,1,0,0,8'h0B,4,0, 0,1);
        addVec(1,1,0,0,8'h0B,4,0, 0,1);
        addVec(0,0,1,0,8'h0B,4,1, 0,1);
        addVec(1,1,0,0,8'h0B,4,1, 0,1);
        addVec(0,1,0,0,8'h0B,4,1, 0,1);
        addVec(1,0,0,0,8'h0B,4,1, 0,1);
        addVec(1,0,0,0,8'h0B,4,1, 0,1);
        addVec(1,0,0,0,8'h0B,4,1, 0,1);
        addVec(1,1,0,0,8'h0B,4,1, 0,1);
        addVec(1,1,0,0,8'h0B,4,1, 1,2);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].b, tbl[i].v, tbl[i].ld, tbl[i].clr,
                          tbl[i].pat, tbl[i].len, tbl[i].ovl);
            check("tbl_seen", int'(seqSeen8), int'(tbl[i].expSeen));
            check("tbl_count", int'(matchCount8), int'(tbl[i].expCnt));
        end

        // Full-length pattern A5 twice back to back, then disabled with len 0
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd8, 1'b1);
        for (int i = 0; i < 16; i++) begin
            bitStep(a5[7 - (i % 8)], 1'b1);
            check("a5_seen", int'(seqSeen8), int'(i == 7 || i == 15));
        end
        check("a5_count", int'(matchCount8), 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            bitStep(a5[7 - (i % 8)], 1'b1);
            check("dis_seen", int'(seqSeen8), 0);
        end
        check("dis_count", int'(matchCount8), 2);

        // Length-1 pattern: every 1 matches; narrow counter saturates, clear wins
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 10; i++) bitStep(1'b1, 1'b1);
        check("sat_count2", int'(matchCount2), 3);
        check("sat_count8", int'(matchCount8), 10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1);
        check("clr_seen", int'(seqSeen8), 1);
        check("clr_count8", int'(matchCount8), 0);
        check("clr_count2", int'(matchCount2), 0);

        // Partial sequence interrupted by reset, then by a reload with a valid bit
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h0B, 4'd4, 1'b1);
        bitStep(1'b1, 1'b1); bitStep(1'b0, 1'b1); bitStep(1'b1, 1'b1);
        doReset();
        bitStep(1'b1, 1'b1);
        check("rst_seen", int'(seqSeen8), 0);
        check("rst_count", int'(matchCount8), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h0B, 4'd4, 1'b1);
        bitStep(1'b1, 1'b1); bitStep(1'b0, 1'b1); bitStep(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h0B, 4'd4, 1'b1);
        check("ld_drop_seen", int'(seqSeen8), 0);
        bitStep(1'b1, 1'b1);
        check("ld_next_seen", int'(seqSeen8), 0);

        // Random traffic with short patterns so matches are frequent
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else if ($urandom_range(0, 24) == 0) begin
                applyStimulus(1'(($urandom)), 1'($urandom), 1'b1,
                              1'($urandom_range(0, 9) == 0), 8'($urandom),
                              4'($urandom_range(0, 10)), 1'($urandom));
            end else begin
                applyStimulus(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0,
                              1'($urandom_range(0, 39) == 0), cfgPattern,
                              cfgLen, cfgOverlap);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
